// File: rtl/isq_pkg.sv
// Shared types for the interrupt sequencer: FSM state encoding, injected
// micro-op codes and a small state-decode helper.
package isq_pkg;

  localparam int ISQ_OP_W        = 3;
  localparam int ISQ_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PUSH_PC_HI = 3'd1,
    PUSH_PC_LO = 3'd2,
    PUSH_FLG   = 3'd3,
    VEC_HI     = 3'd4,
    VEC_LO     = 3'd5,
    JUMP       = 3'd6
  } isq_state_t;

  typedef enum logic [ISQ_OP_W-1:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_VEC  = 3'd2
  } isq_op_t;

  // States in which decode consumes an injected micro-op instead of fetch.
  function automatic logic isq_injects(input isq_state_t s);
    return (s == PUSH_PC_HI) || (s == PUSH_PC_LO) || (s == PUSH_FLG) || (s == VEC_HI);
  endfunction

endpackage

// File: rtl/isq_if.sv
// Bundle of everything the interrupt sequencer exchanges with the pipeline,
// hazard unit and data memory. The sequencer is the master side.
interface isq_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 16,
  parameter int FLAG_W = 3
) ();

  logic              i_int;
  logic              i_stall_interrupt;
  logic              i_stall;
  logic [PC_W-1:0]   i_pc;
  logic [FLAG_W-1:0] i_flags;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_interrupt_call;
  logic              o_busy;
  logic              o_inject_valid;
  logic [2:0]        o_inject_op;
  logic [DATA_W-1:0] o_push_data;
  logic              o_mem_rd;
  logic [PC_W-1:0]   o_mem_addr;
  logic              o_redirect;
  logic [PC_W-1:0]   o_target;

  modport master (
    input  i_int, i_stall_interrupt, i_stall, i_pc, i_flags, i_mem_rdata,
    output o_interrupt_call, o_busy, o_inject_valid, o_inject_op, o_push_data,
           o_mem_rd, o_mem_addr, o_redirect, o_target
  );

  modport slave (
    output i_int, i_stall_interrupt, i_stall, i_pc, i_flags, i_mem_rdata,
    input  o_interrupt_call, o_busy, o_inject_valid, o_inject_op, o_push_data,
           o_mem_rd, o_mem_addr, o_redirect, o_target
  );

endinterface

// File: rtl/isq_edge_sync.sv
// Rising-edge detector for the interrupt request line.
// Build option ISQ_SYNC_EN: when defined, the request first passes a
// two-flop synchronizer (adds two cycles of latency); when undefined the
// request is assumed synchronous and is edge-detected directly.
module isq_edge_sync
  import isq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sampled;
  logic prev_reg;

`ifdef ISQ_SYNC_EN
  logic [ISQ_SYNC_STAGES-1:0] sync_reg;

  // Shift the asynchronous request through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[ISQ_SYNC_STAGES-2:0], din};
    end
  end

  assign sampled = sync_reg[ISQ_SYNC_STAGES-1];
`else
  assign sampled = din;
`endif

  // Remember last cycle's level so a held-high request yields one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= sampled;
    end
  end

  assign rise = sampled & ~prev_reg;

endmodule

// File: rtl/interrupt_sequencer.sv
// Initiator side of the hazard unit's interrupt handshake. Latches an
// interrupt event, waits for the hazard unit to clear, then injects
// PUSH pc_hi, PUSH pc_lo, PUSH flags, vector fetch, and ends with a
// redirect that the pipeline treats as a taken branch.
// Build option ISQ_SYNC_EN (see isq_edge_sync) adds a request synchronizer.
module interrupt_sequencer
  import isq_pkg::*;
#(
  parameter int              PC_W     = 32,  // must equal 2*DATA_W
  parameter int              DATA_W   = 16,
  parameter int              FLAG_W   = 3,
  parameter logic [PC_W-1:0] VEC_ADDR = '0
) (
  input  logic  i_clk,
  input  logic  i_rst,
  isq_if.master bus
);

  // Low half of the vector lives one word above; wraps modulo 2^PC_W.
  localparam logic [PC_W-1:0] VEC_ADDR_LO = VEC_ADDR + PC_W'(1);

  isq_state_t        state_reg, state_next;
  logic              pending_reg;
  logic [PC_W-1:0]   saved_pc_reg;
  logic [FLAG_W-1:0] saved_flags_reg;
  logic [DATA_W-1:0] vec_hi_reg;
  logic [DATA_W-1:0] vec_lo_reg;
  logic              held_reg;

  logic              int_rise;
  logic              start;
  logic [DATA_W-1:0] vec_lo_now;

  logic              call;
  logic              busy;
  logic              inject_valid;
  isq_op_t           inject_op;
  logic [DATA_W-1:0] push_data;
  logic              mem_rd;
  logic [PC_W-1:0]   mem_addr;
  logic              redirect;
  logic [PC_W-1:0]   target;

  isq_edge_sync u_edge_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .din  (bus.i_int),
    .rise (int_rise)
  );

  // A stalled cycle repeats the current state; the data-memory read of the
  // previous state already returned, so vector halves are only latched on
  // the first cycle spent in VEC_LO / JUMP, and JUMP falls back to the
  // registered low half once rdata may have moved on.
  assign vec_lo_now = held_reg ? vec_lo_reg : bus.i_mem_rdata;

  // Next-state and output decode for the injection sequence.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    call       = 1'b0;
    inject_op  = OP_NONE;
    push_data  = '0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    redirect   = 1'b0;
    target     = '0;

    case (state_reg)
      IDLE: begin
        call = pending_reg;
        if (pending_reg && !bus.i_stall_interrupt) begin
          start      = 1'b1;
          state_next = PUSH_PC_HI;
        end
      end
      PUSH_PC_HI: begin
        inject_op  = OP_PUSH;
        push_data  = saved_pc_reg[PC_W-1:DATA_W];
        state_next = PUSH_PC_LO;
      end
      PUSH_PC_LO: begin
        inject_op  = OP_PUSH;
        push_data  = saved_pc_reg[DATA_W-1:0];
        state_next = PUSH_FLG;
      end
      PUSH_FLG: begin
        inject_op  = OP_PUSH;
        push_data  = DATA_W'(saved_flags_reg);
        state_next = VEC_HI;
      end
      VEC_HI: begin
        inject_op  = OP_VEC;
        mem_rd     = 1'b1;
        mem_addr   = VEC_ADDR;
        state_next = VEC_LO;
      end
      VEC_LO: begin
        mem_rd     = 1'b1;
        mem_addr   = VEC_ADDR_LO;
        state_next = JUMP;
      end
      JUMP: begin
        redirect   = 1'b1;
        target     = {vec_hi_reg, vec_lo_now};
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A pipeline stall freezes the sequence; outputs simply hold.
    if (bus.i_stall) begin
      state_next = state_reg;
      start      = 1'b0;
    end
  end

  assign busy         = (state_reg != IDLE);
  assign inject_valid = isq_injects(state_reg);

  // Sequence state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // One-deep pending flag: set by an edge, cleared when the sequence starts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_reg <= 1'b0;
    end else if (start) begin
      pending_reg <= 1'b0;
    end else if (int_rise) begin
      pending_reg <= 1'b1;
    end
  end

  // Return context captured on the cycle the sequence is launched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      saved_pc_reg    <= '0;
      saved_flags_reg <= '0;
    end else if (start) begin
      saved_pc_reg    <= bus.i_pc;
      saved_flags_reg <= bus.i_flags;
    end
  end

  // Tracks whether the current cycle repeats a stalled one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      held_reg <= 1'b0;
    end else begin
      held_reg <= bus.i_stall;
    end
  end

  // Vector halves arrive one cycle after their read strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vec_hi_reg <= '0;
      vec_lo_reg <= '0;
    end else begin
      if (state_reg == VEC_LO && !held_reg) begin
        vec_hi_reg <= bus.i_mem_rdata;
      end
      if (state_reg == JUMP && !held_reg) begin
        vec_lo_reg <= bus.i_mem_rdata;
      end
    end
  end

  assign bus.o_interrupt_call = call;
  assign bus.o_busy           = busy;
  assign bus.o_inject_valid   = inject_valid;
  assign bus.o_inject_op      = inject_op;
  assign bus.o_push_data      = push_data;
  assign bus.o_mem_rd         = mem_rd;
  assign bus.o_mem_addr       = mem_addr;
  assign bus.o_redirect       = redirect;
  assign bus.o_target         = target;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer. Stamp k means "state after the
// k-th rising edge"; inputs driven at stamp k are captured by edge k+1.
`timescale 1ns/1ps
module tb_interrupt_sequencer;
  import isq_pkg::*;

`ifdef ISQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isq_if bus ();

  interrupt_sequencer dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Vector memory model: one-cycle read latency.
  logic [15:0] vec_hi = 16'h0000;
  logic [15:0] vec_lo = 16'h0200;
  always @(posedge clk) begin
    if (bus.o_mem_rd) begin
      if (bus.o_mem_addr == 32'd0)      bus.i_mem_rdata <= vec_hi;
      else if (bus.o_mem_addr == 32'd1) bus.i_mem_rdata <= vec_lo;
      else                              bus.i_mem_rdata <= 16'hBEEF;
    end else begin
      bus.i_mem_rdata <= 16'hBEEF;
    end
  end

  // Monitor logs, sampled mid-cycle.
  logic [63:0] push_q[$];
  logic [63:0] push_cyc_q[$];
  logic [63:0] stall_push_q[$];
  logic [63:0] redir_cyc_q[$];
  logic [63:0] target_q[$];
  logic [63:0] call_cyc_q[$];
  logic [63:0] addr_q[$];
  logic [63:0] addr_cyc_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_inject_valid && bus.o_inject_op == OP_PUSH) begin
        if (bus.i_stall) begin
          stall_push_q.push_back(64'(bus.o_push_data));
        end else begin
          push_q.push_back(64'(bus.o_push_data));
          push_cyc_q.push_back(64'(cyc_cnt));
        end
      end
      if (bus.o_redirect && !bus.i_stall) begin
        redir_cyc_q.push_back(64'(cyc_cnt));
        target_q.push_back(64'(bus.o_target));
        $display("txn: redirect at cycle %0d target=%08h", cyc_cnt, bus.o_target);
      end
      if (bus.o_interrupt_call) call_cyc_q.push_back(64'(cyc_cnt));
      if (bus.o_mem_rd && !bus.i_stall) begin
        addr_q.push_back(64'(bus.o_mem_addr));
        addr_cyc_q.push_back(64'(cyc_cnt));
      end
    end
  end

  int n_errors = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_stamp(input int k);
    while (cyc_cnt < k) tick();
  endtask

  task automatic clear_log();
    push_q.delete();
    push_cyc_q.delete();
    stall_push_q.delete();
    redir_cyc_q.delete();
    target_q.delete();
    call_cyc_q.delete();
    addr_q.delete();
    addr_cyc_q.delete();
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_busy"},     64'(bus.o_busy), 64'd0);
    check({pfx, "_call"},     64'(bus.o_interrupt_call), 64'd0);
    check({pfx, "_inj"},      64'(bus.o_inject_valid), 64'd0);
    check({pfx, "_op"},       64'(bus.o_inject_op), 64'd0);
    check({pfx, "_push"},     64'(bus.o_push_data), 64'd0);
    check({pfx, "_memrd"},    64'(bus.o_mem_rd), 64'd0);
    check({pfx, "_memaddr"},  64'(bus.o_mem_addr), 64'd0);
    check({pfx, "_redirect"}, 64'(bus.o_redirect), 64'd0);
    check({pfx, "_target"},   64'(bus.o_target), 64'd0);
  endtask

  int n;
  int p;

  initial begin
    bus.i_int             = 1'b0;
    bus.i_stall_interrupt = 1'b0;
    bus.i_stall           = 1'b0;
    bus.i_pc              = 32'h0;
    bus.i_flags           = 3'b000;
    rst = 1'b1;
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    tick(4);

    // 1: plain sequence, no stalls.
    clear_log();
    bus.i_pc = 32'h0000_1234; bus.i_flags = 3'b101;
    vec_hi = 16'h0000; vec_lo = 16'h0200;
    n = cyc_cnt; bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    p = n + 1 + L;
    tick(12 + L);
    check("t1_call_cyc",  qat(call_cyc_q, 0), 64'(p));
    check("t1_call_len",  64'(call_cyc_q.size()), 64'd1);
    check("t1_push0",     qat(push_q, 0), 64'h0000);
    check("t1_push1",     qat(push_q, 1), 64'h1234);
    check("t1_push2",     qat(push_q, 2), 64'h0005);
    check("t1_push_cyc",  qat(push_cyc_q, 0), 64'(p + 1));
    check("t1_addr0",     qat(addr_q, 0), 64'h0);
    check("t1_addr1",     qat(addr_q, 1), 64'h1);
    check("t1_addr_cyc",  qat(addr_cyc_q, 0), 64'(p + 4));
    check("t1_redir_n",   64'(redir_cyc_q.size()), 64'd1);
    check("t1_redir_cyc", qat(redir_cyc_q, 0), 64'(n + 7 + L));
    check("t1_target",    qat(target_q, 0), 64'h0000_0200);

    // 2: hazard unit holds off three cycles; PC captured at release.
    clear_log(); tick(5);
    bus.i_stall_interrupt = 1'b1; bus.i_pc = 32'h1111_2222;
    n = cyc_cnt; bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    p = n + 1 + L;
    wait_stamp(p + 3);
    bus.i_stall_interrupt = 1'b0; bus.i_pc = 32'h00C0_ABCD;
    tick(); bus.i_pc = 32'h5555_6666;
    tick(12);
    check("t2_call_len",  64'(call_cyc_q.size()), 64'd4);
    check("t2_call_first", qat(call_cyc_q, 0), 64'(p));
    check("t2_call_last", qat(call_cyc_q, 3), 64'(p + 3));
    check("t2_push_cyc",  qat(push_cyc_q, 0), 64'(p + 4));
    check("t2_push0",     qat(push_q, 0), 64'h00C0);
    check("t2_push1",     qat(push_q, 1), 64'hABCD);
    check("t2_redir_cyc", qat(redir_cyc_q, 0), 64'(p + 9));

    // 3: pipeline stall for two cycles in PUSH_PC_LO.
    clear_log(); tick(5);
    bus.i_pc = 32'h0000_1234; vec_hi = 16'h1234; vec_lo = 16'h5678;
    n = cyc_cnt; bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    p = n + 1 + L;
    wait_stamp(p + 2);
    bus.i_stall = 1'b1; tick(2); bus.i_stall = 1'b0;
    tick(12);
    check("t3_stall_len", 64'(stall_push_q.size()), 64'd2);
    check("t3_stall_d0",  qat(stall_push_q, 0), 64'h1234);
    check("t3_stall_d1",  qat(stall_push_q, 1), 64'h1234);
    check("t3_push_len",  64'(push_q.size()), 64'd3);
    check("t3_push1_cyc", qat(push_cyc_q, 1), 64'(p + 4));
    check("t3_redir_cyc", qat(redir_cyc_q, 0), 64'(p + 8));
    check("t3_target",    qat(target_q, 0), 64'h1234_5678);

    // 4: second edge during PUSH_FLG is served after return to IDLE.
    clear_log(); tick(5);
    vec_hi = 16'h0000; vec_lo = 16'h0200;
    n = cyc_cnt; bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    p = n + 1 + L;
    wait_stamp(p + 3);
    bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    tick(20);
    check("t4_call_len",  64'(call_cyc_q.size()), 64'd2);
    check("t4_call2_cyc", qat(call_cyc_q, 1), 64'(p + 7));
    check("t4_redir_n",   64'(redir_cyc_q.size()), 64'd2);
    check("t4_redir0",    qat(redir_cyc_q, 0), 64'(p + 6));
    check("t4_redir1",    qat(redir_cyc_q, 1), 64'(p + 13));
    check("t4_push_len",  64'(push_q.size()), 64'd6);

    // 5: reset in VEC_LO with another request pending.
    clear_log(); tick(5);
    n = cyc_cnt; bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    p = n + 1 + L;
    wait_stamp(p + 2);
    bus.i_int = 1'b1; tick(); bus.i_int = 1'b0;
    wait_stamp(p + 5);
    check("t5_in_veclo",  64'(bus.o_mem_addr), 64'h1);
    rst = 1'b1; tick();
    check_quiet("t5_after_rst");
    rst = 1'b0;
    tick(12);
    check("t5_redir_n",   64'(redir_cyc_q.size()), 64'd0);
    check("t5_call_len",  64'(call_cyc_q.size()), 64'd1);

    // 6: level held high for 20 cycles gives exactly one sequence.
    clear_log(); tick(5);
    n = cyc_cnt; bus.i_int = 1'b1; tick(20); bus.i_int = 1'b0;
    p = n + 1 + L;
    tick(15);
    check("t6_call_cyc",  qat(call_cyc_q, 0), 64'(p));
    check("t6_call_len",  64'(call_cyc_q.size()), 64'd1);
    check("t6_redir_n",   64'(redir_cyc_q.size()), 64'd1);
    check("t6_redir_cyc", qat(redir_cyc_q, 0), 64'(p + 6));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
